// File: rtl/sseg_bin2bcd_pkg.sv
// Shared constants and state encoding for the
// display-side binary-to-BCD converter.
package sseg_bin2bcd_pkg;

  localparam int SSEG_DIGITS        = 8;
  localparam int BCD_SCRATCH_DIGITS = 10;
  localparam int NUM_W              = SSEG_DIGITS * 4;
  localparam int SCRATCH_W          = BCD_SCRATCH_DIGITS * 4;

  localparam logic [NUM_W-1:0] ERR_PATTERN_DEF = 32'hEEEEEEEE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

endpackage

// File: rtl/sseg_dd_step.sv
// Add-3 correction applied to every BCD digit
// before each double-dabble shift.
module sseg_dd_step #(
  parameter int DIGITS = 10
) (
  input  logic [DIGITS*4-1:0] d,
  output logic [DIGITS*4-1:0] q
);

  // A digit of 5..9 becomes 8..12, so the 4-bit add never carries
  always_comb begin
    q = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[i*4 +: 4] >= 4'd5)
        q[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/sseg_bin2bcd.sv
// Binary to packed-BCD converter feeding the
// seven-segment driver; hex passthrough or decimal.
module sseg_bin2bcd
  import sseg_bin2bcd_pkg::*;
#(
  parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DEF,
  parameter int          ITERS       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_bin,
  input  logic        in_mode,
  output logic [31:0] num,
  output logic        done,
  output logic        overflow
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  state_t               state;
  logic [31:0]          shreg;
  logic [SCRATCH_W-1:0] scratch;
  logic [SCRATCH_W-1:0] corr;
  logic [CNT_W-1:0]     cnt;

  sseg_dd_step #(
    .DIGITS(BCD_SCRATCH_DIGITS)
  ) u_step (
    .d(scratch),
    .q(corr)
  );

  // Request handshake, shift engine and held result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      num      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      in_ready <= 1'b1;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            overflow <= 1'b0;
            if (!in_mode) begin
              num  <= in_bin;
              done <= 1'b1;
            end else begin
              shreg    <= in_bin;
              scratch  <= '0;
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          {scratch, shreg} <= {corr, shreg} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_FINISH;
        end
        S_FINISH: begin
          if (|scratch[SCRATCH_W-1:32]) begin
            num      <= ERR_PATTERN;
            overflow <= 1'b1;
          end else begin
            num <= scratch[31:0];
          end
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
